// File: rtl/dp_types_pkg.sv
// Shared types and default sizing for the memory request sequencer.
// The watchdog defaults can be overridden per instance of mem_request_unit.
package dp_types_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2,
    ERROR  = 2'd3
  } req_state_t;

  localparam int TIMEOUT_CYCLES_DEF = 255;
  localparam int CNT_W_DEF          = 8;

endpackage

// File: rtl/mem_request_unit_req_watchdog.sv
// Saturating count of consecutive DATA cycles without dhit.
// expired flags the last allowed stall cycle; a zero timeout disables it.
module req_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Compare on the current count so the stall cycle that reaches the limit is the last one.
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_request_unit.sv
// Turns decoded per-instruction memory intent into imem/dmem requests,
// gating PC advance until the access completes; owns sticky halt and watchdog error.
module mem_request_unit
  import dp_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic CLK,
  input  logic nRST,
  input  logic dREN_in,
  input  logic dWEN_in,
  input  logic halt_in,
  input  logic ihit,
  input  logic dhit,
  output logic imemREN,
  output logic dmemREN,
  output logic dmemWEN,
  output logic pc_en,
  output logic halt,
  output logic err
);

  req_state_t state_q, state_d;
  logic       dren_q, dren_d;
  logic       dwen_q, dwen_d;
  logic       halt_q, halt_d;
  logic       err_q, err_d;
  logic       pc_en_c;
  logic       wd_clear, wd_count, wd_expired;

  assign wd_clear = (state_q != DATA);
  assign wd_count = (state_q == DATA) && !dhit;

  req_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (wd_clear),
    .count_en(wd_count),
    .expired (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    dren_d  = dren_q;
    dwen_d  = dwen_q;
    halt_d  = halt_q;
    err_d   = err_q;
    pc_en_c = 1'b0;
    case (state_q)
      FETCH: begin
        if (ihit) begin
          if (halt_in) begin
            state_d = HALTED;
            halt_d  = 1'b1;
          end else if (dREN_in || dWEN_in) begin
            // A store wins when both intents are decoded.
            state_d = DATA;
            dwen_d  = dWEN_in;
            dren_d  = dREN_in && !dWEN_in;
          end else begin
            pc_en_c = 1'b1;
          end
        end
      end
      DATA: begin
        if (dhit) begin
          state_d = FETCH;
          pc_en_c = 1'b1;
          dren_d  = 1'b0;
          dwen_d  = 1'b0;
        end else if (wd_expired) begin
          state_d = ERROR;
          err_d   = 1'b1;
          halt_d  = 1'b1;
          dren_d  = 1'b0;
          dwen_d  = 1'b0;
        end
      end
      default: begin
        dren_d = 1'b0;
        dwen_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FETCH;
      dren_q  <= 1'b0;
      dwen_q  <= 1'b0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dren_q  <= dren_d;
      dwen_q  <= dwen_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
    end
  end

  // PC must not move while reset is held, even if memory reports ihit.
  assign pc_en    = pc_en_c && nRST;
  assign imemREN  = (state_q == FETCH);
  assign dmemREN  = dren_q;
  assign dmemWEN  = dwen_q;
  assign halt     = halt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_request_unit.sv
// Scoreboard bench for mem_request_unit: default-timeout and 4-cycle-timeout instances
// share stimulus; sel chooses which one the monitor compares.
module tb_mem_request_unit;

  logic CLK = 1'b0;
  logic nRST;
  logic dREN_in, dWEN_in, halt_in, ihit, dhit;
  logic sel;

  logic imemREN_a, dmemREN_a, dmemWEN_a, pc_en_a, halt_a, err_a;
  logic imemREN_b, dmemREN_b, dmemWEN_b, pc_en_b, halt_b, err_b;
  logic [5:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] sb_exp[$];
  string      sb_tag[$];

  always #5 CLK = ~CLK;

  mem_request_unit u_dut (
    .CLK(CLK), .nRST(nRST), .dREN_in(dREN_in), .dWEN_in(dWEN_in), .halt_in(halt_in),
    .ihit(ihit), .dhit(dhit), .imemREN(imemREN_a), .dmemREN(dmemREN_a),
    .dmemWEN(dmemWEN_a), .pc_en(pc_en_a), .halt(halt_a), .err(err_a)
  );

  mem_request_unit #(.TIMEOUT_CYCLES(4), .CNT_W(3)) u_dut_to (
    .CLK(CLK), .nRST(nRST), .dREN_in(dREN_in), .dWEN_in(dWEN_in), .halt_in(halt_in),
    .ihit(ihit), .dhit(dhit), .imemREN(imemREN_b), .dmemREN(dmemREN_b),
    .dmemWEN(dmemWEN_b), .pc_en(pc_en_b), .halt(halt_b), .err(err_b)
  );

  // Packed as {imemREN, dmemREN, dmemWEN, pc_en, halt, err}.
  assign obs = sel ? {imemREN_b, dmemREN_b, dmemWEN_b, pc_en_b, halt_b, err_b}
                   : {imemREN_a, dmemREN_a, dmemWEN_a, pc_en_a, halt_a, err_a};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, act[5:0], exp[5:0]);
    end
  endtask

  task automatic drive(input logic ih, input logic dh, input logic dr, input logic dw,
                       input logic hl, input logic [5:0] e, input string tag);
    ihit    = ih;
    dhit    = dh;
    dREN_in = dr;
    dWEN_in = dw;
    halt_in = hl;
    sb_exp.push_back(e);
    sb_tag.push_back(tag);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    sel = 1'b0;
    nRST = 1'b0;
    {ihit, dhit, dREN_in, dWEN_in, halt_in} = '0;

    fork
      forever begin
        @(negedge CLK);
        if (sb_exp.size() > 0) begin
          logic [5:0] e;
          string t;
          e = sb_exp.pop_front();
          t = sb_tag.pop_front();
          check_eq(t, {26'd0, obs}, {26'd0, e});
        end
      end
    join_none

    #3;
    check_eq("reset_state", {26'd0, obs}, 32'b100000);
    @(posedge CLK); #1;
    drive(1, 0, 0, 0, 0, 6'b100000, "reset_ihit_no_pc_en");
    nRST = 1'b1;

    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 6'b100100, "seq_fetch");

    drive(1, 0, 1, 0, 0, 6'b100000, "ld_issue");
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 6'b010000, "ld_wait");
    drive(0, 1, 0, 0, 0, 6'b010100, "ld_dhit");
    drive(0, 0, 0, 0, 0, 6'b100000, "ld_back_fetch");

    drive(1, 0, 1, 1, 0, 6'b100000, "rw_issue");
    drive(0, 0, 0, 0, 0, 6'b001000, "rw_wait");
    drive(0, 1, 0, 0, 0, 6'b001100, "rw_dhit");
    drive(0, 1, 0, 0, 0, 6'b100000, "fetch_ignores_dhit");

    drive(1, 0, 1, 0, 0, 6'b100000, "rst_ld_issue");
    drive(0, 0, 0, 0, 0, 6'b010000, "rst_ld_wait");
    nRST = 1'b0;
    #1;
    check_eq("rst_async_drop", {26'd0, obs}, 32'b100000);
    drive(0, 0, 0, 0, 0, 6'b100000, "rst_hold");
    nRST = 1'b1;
    drive(0, 0, 0, 0, 0, 6'b100000, "rst_release");

    drive(1, 0, 0, 1, 1, 6'b100000, "halt_issue");
    drive(1, 1, 0, 0, 0, 6'b000010, "halted_1");
    drive(1, 1, 1, 1, 0, 6'b000010, "halted_2");
    drive(0, 1, 0, 0, 0, 6'b000010, "halted_3");

    nRST = 1'b0;
    drive(0, 0, 0, 0, 0, 6'b100000, "halt_cleared");
    nRST = 1'b1;

    sel = 1'b1;
    drive(1, 0, 0, 1, 0, 6'b100000, "to_issue");
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 6'b001000, "to_wait");
    drive(1, 1, 0, 0, 0, 6'b000011, "to_error");
    drive(1, 0, 1, 0, 0, 6'b000011, "to_error_sticky");

    nRST = 1'b0;
    drive(0, 0, 0, 0, 0, 6'b100000, "to_reset");
    nRST = 1'b1;
    drive(1, 0, 0, 1, 0, 6'b100000, "hit4_issue");
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 6'b001000, "hit4_wait");
    drive(0, 1, 0, 0, 0, 6'b001100, "hit4_dhit_wins");
    drive(0, 0, 0, 0, 0, 6'b100000, "hit4_fetch_no_err");

    check_eq("sb_drain", sb_exp.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
